transmission_splitter: RTL and testbench

Splits one configured DMA transfer (host address, device address, byte length) into a sequence of PCIe-legal chunks. Each chunk is capped by the Max Read Request Size or Max Payload Size from the PCIe Device Control register and never crosses a 4 KB host-address boundary. It sits between the DMA register block and the read/write request engines. Chunks are handed out one at a time with a pending/done handshake.

---
 rtl/transmission_splitter.sv | 152 +++++++++++++++
 tb/tb_transmission_splitter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmission_splitter.sv
// transmission_splitter
// Breaks one DMA transfer (host address, device address, byte length) into
// PCIe-legal chunks. Each chunk is capped by the Max Read Request Size (reads)
// or Max Payload Size (writes) taken from the Device Control register. A chunk
// never crosses a 4 KB host-address boundary. Chunks are offered one at a time
// with a pending/done handshake.
//
// Optional feature macro: TRANSMISSION_SPLITTER_ALIGN_EN
//   When defined, every chunk is also kept inside one limit-sized, limit-aligned
//   host window. After the first chunk, each chunk therefore starts aligned to
//   the limit.

module transmission_splitter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] pcie_dcommand,
    input  logic [31:0] conf_start_address_host,
    input  logic [31:0] conf_start_address_device,
    input  logic [31:0] conf_size,
    input  logic        conf_dir_write,
    input  logic        conf_valid,
    output logic        dma_pending,
    input  logic        dma_done,
    output logic [31:0] dma_address_host,
    output logic [31:0] dma_address_device,
    output logic [9:0]  dma_size
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Maps the 3-bit PCIe size encoding onto a byte count. Encodings above
    // 512 B are clamped because the chunk size field is only 10 bits wide.
    function automatic logic [9:0] decode_limit(input logic [2:0] field);
        logic [9:0] bytes;
        case (field)
            3'd0:    bytes = 10'd128;
            3'd1:    bytes = 10'd256;
            default: bytes = 10'd512;
        endcase
        return bytes;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] host_q, host_d;
    logic [31:0] dev_q, dev_d;
    logic [31:0] rem_q, rem_d;
    logic [9:0]  limit_q, limit_d;
    logic [9:0]  size_q, size_d;

    logic [12:0] boundary_room;
    logic [9:0]  chunk_size;
    logic [31:0] cfg_size;
    logic [2:0]  cfg_limit_field;

    // Only the two size fields of Device Control matter here.
    logic        unused_dcommand_bits;
    assign unused_dcommand_bits = ^{pcie_dcommand[15], pcie_dcommand[11:8], pcie_dcommand[4:0]};

`ifdef TRANSMISSION_SPLITTER_ALIGN_EN
    logic [9:0]  align_room;
`endif

    // Size of the next chunk: the smallest of the limit, the bytes left before
    // the next 4 KB host boundary, and the bytes still to be transferred.
    always_comb begin
        boundary_room = 13'd4096 - {1'b0, host_q[11:0]};
        chunk_size    = limit_q;
        if ({19'd0, boundary_room} < {22'd0, chunk_size}) begin
            chunk_size = boundary_room[9:0];
        end
        if (rem_q < {22'd0, chunk_size}) begin
            chunk_size = rem_q[9:0];
        end
`ifdef TRANSMISSION_SPLITTER_ALIGN_EN
        // The limit is a power of two, so (limit - 1) masks host mod limit.
        align_room = limit_q - (host_q[9:0] & (limit_q - 10'd1));
        if (align_room < chunk_size) begin
            chunk_size = align_room;
        end
`endif
    end

    // Next-state logic: latch a new transfer in IDLE, register the chunk size
    // in CALC, and advance the addresses once the consumer takes a chunk.
    always_comb begin
        state_d         = state_q;
        host_d          = host_q;
        dev_d           = dev_q;
        rem_d           = rem_q;
        limit_d         = limit_q;
        size_d          = size_q;
        cfg_size        = conf_size & ~32'd3;
        cfg_limit_field = conf_dir_write ? pcie_dcommand[7:5] : pcie_dcommand[14:12];

        case (state_q)
            ST_IDLE: begin
                // A zero-length request leaves the block, and its outputs, untouched.
                if (conf_valid && (cfg_size != 32'd0)) begin
                    host_d  = conf_start_address_host & ~32'd3;
                    dev_d   = conf_start_address_device & ~32'd3;
                    rem_d   = cfg_size;
                    limit_d = decode_limit(cfg_limit_field);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                size_d  = chunk_size;
                state_d = ST_PEND;
            end
            ST_PEND: begin
                if (dma_done) begin
                    host_d  = host_q + {22'd0, size_q};
                    dev_d   = dev_q + {22'd0, size_q};
                    rem_d   = rem_q - {22'd0, size_q};
                    state_d = (rem_d != 32'd0) ? ST_CALC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            host_q  <= 32'd0;
            dev_q   <= 32'd0;
            rem_q   <= 32'd0;
            limit_q <= 10'd128;
            size_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            host_q  <= host_d;
            dev_q   <= dev_d;
            rem_q   <= rem_d;
            limit_q <= limit_d;
            size_q  <= size_d;
        end
    end

    assign dma_pending        = (state_q == ST_PEND);
    assign dma_address_host   = host_q;
    assign dma_address_device = dev_q;
    assign dma_size           = size_q;

endmodule

// File: tb/tb_transmission_splitter.sv
// Testbench for transmission_splitter. Directed cases from the chunking rules
// plus randomized transfers checked against a queue-based reference model.
// Honours TRANSMISSION_SPLITTER_ALIGN_EN the same way the design does.

module tb_transmission_splitter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] pcie_dcommand;
    logic [31:0] conf_start_address_host;
    logic [31:0] conf_start_address_device;
    logic [31:0] conf_size;
    logic        conf_dir_write;
    logic        conf_valid;
    logic        dma_pending;
    logic        dma_done;
    logic [31:0] dma_address_host;
    logic [31:0] dma_address_device;
    logic [9:0]  dma_size;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_host[$];
    logic [31:0] exp_dev[$];
    logic [31:0] exp_size[$];

    transmission_splitter dut (
        .i_clk                     (i_clk),
        .i_rst                     (i_rst),
        .pcie_dcommand             (pcie_dcommand),
        .conf_start_address_host   (conf_start_address_host),
        .conf_start_address_device (conf_start_address_device),
        .conf_size                 (conf_size),
        .conf_dir_write            (conf_dir_write),
        .conf_valid                (conf_valid),
        .dma_pending               (dma_pending),
        .dma_done                  (dma_done),
        .dma_address_host          (dma_address_host),
        .dma_address_device        (dma_address_device),
        .dma_size                  (dma_size)
    );

    // 10 ns clock
    always #5 i_clk = ~i_clk;

    // Safety net so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_exp();
        exp_host.delete();
        exp_dev.delete();
        exp_size.delete();
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] d, input logic [31:0] s);
        exp_host.push_back(h);
        exp_dev.push_back(d);
        exp_size.push_back(s);
    endtask

    // Reference model: walk the transfer taking the largest legal bite each time
    task automatic model_build(input logic [31:0] h, input logic [31:0] d, input logic [31:0] s,
                               input logic dir, input logic [15:0] dc);
        logic [31:0] host;
        logic [31:0] dev;
        logic [31:0] rem;
        logic [2:0]  f;
        int unsigned lim;
        int unsigned c;
        int unsigned room;
        clear_exp();
        f    = dir ? dc[7:5] : dc[14:12];
        lim  = (f == 3'd0) ? 128 : (f == 3'd1) ? 256 : 512;
        host = h & ~32'd3;
        dev  = d & ~32'd3;
        rem  = s & ~32'd3;
        while (rem != 0) begin
            c = rem;
            if (lim < c) c = lim;
            room = 4096 - (host % 4096);
            if (room < c) c = room;
`ifdef TRANSMISSION_SPLITTER_ALIGN_EN
            room = lim - (host % lim);
            if (room < c) c = room;
`endif
            push_exp(host, dev, c);
            host += c;
            dev  += c;
            rem  -= c;
        end
    endtask

    // Pulse conf_valid for one cycle; the following cycle must not be pending
    task automatic start_transfer(input string tag, input logic [31:0] h, input logic [31:0] d,
                                  input logic [31:0] s, input logic dir, input logic [15:0] dc);
        @(negedge i_clk);
        conf_start_address_host   = h;
        conf_start_address_device = d;
        conf_size                 = s;
        conf_dir_write            = dir;
        pcie_dcommand             = dc;
        conf_valid                = 1'b1;
        @(negedge i_clk);
        conf_valid = 1'b0;
        n_checks++;
        if (dma_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s start_bubble: dma_pending=%b required 0", tag, dma_pending);
        end
    endtask

    // Wait (bounded) for a chunk and compare it against the expectation
    task automatic wait_chunk(input string tag, input int idx, input int exp_wait);
        int waited = 0;
        while (dma_pending !== 1'b1 && waited < 16) begin
            @(negedge i_clk);
            waited++;
        end
        n_checks++;
        if (dma_pending !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d timeout: dma_pending=%b required 1", tag, idx, dma_pending);
            return;
        end
        n_checks++;
        if (waited != exp_wait) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d latency: got %0d extra cycles, required %0d", tag, idx, waited, exp_wait);
        end
        n_checks++;
        if (dma_address_host !== exp_host[idx]) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d host: got %h required %h", tag, idx, dma_address_host, exp_host[idx]);
        end
        n_checks++;
        if (dma_address_device !== exp_dev[idx]) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d device: got %h required %h", tag, idx, dma_address_device, exp_dev[idx]);
        end
        n_checks++;
        if ({22'd0, dma_size} !== exp_size[idx]) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d size: got %0d required %0d", tag, idx, dma_size, exp_size[idx]);
        end
    endtask

    // Assert dma_done for done_len cycles (1 or 2); optionally collide with conf_valid
    task automatic accept_chunk(input string tag, input int idx, input int done_len,
                                input bit conf_too, output int next_wait);
        dma_done = 1'b1;
        if (conf_too) begin
            conf_valid              = 1'b1;
            conf_size               = 32'h0000_0400;
            conf_start_address_host = $urandom;
        end
        @(negedge i_clk);
        conf_valid = 1'b0;
        n_checks++;
        if (dma_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s chunk%0d done_bubble: dma_pending=%b required 0", tag, idx, dma_pending);
        end
        if (done_len >= 2) begin
            @(negedge i_clk);
            next_wait = 0;
        end else begin
            next_wait = 1;
        end
        dma_done = 1'b0;
    endtask

    // Run a whole transfer against exp_* ; done_len 0 means random 1..2
    task automatic run_transfer(input string tag, input logic [31:0] h, input logic [31:0] d,
                                input logic [31:0] s, input logic dir, input logic [15:0] dc,
                                input int done_len, input bit noise, input bit rand_hold);
        int  nw;
        int  hold;
        int  dl;
        bit  busy_seen;
        start_transfer(tag, h, d, s, dir, dc);
        nw = 1;
        for (int i = 0; i < exp_size.size(); i++) begin
            wait_chunk(tag, i, nw);
            hold = rand_hold ? $urandom_range(0, 3) : 0;
            if (noise) hold = hold + 1;
            for (int k = 0; k < hold; k++) begin
                if (noise && k == 0) begin
                    conf_valid                = 1'b1;
                    conf_start_address_host   = $urandom;
                    conf_start_address_device = $urandom;
                    conf_size                 = $urandom | 32'h100;
                end
                @(negedge i_clk);
                conf_valid = 1'b0;
            end
            if (hold > 0) begin
                n_checks++;
                if (dma_pending !== 1'b1 || dma_address_host !== exp_host[i] ||
                    dma_address_device !== exp_dev[i] || {22'd0, dma_size} !== exp_size[i]) begin
                    n_fail++;
                    $display("[TB] FAIL %s chunk%0d hold_stable: pend=%b host=%h dev=%h size=%0d required 1/%h/%h/%0d",
                             tag, i, dma_pending, dma_address_host, dma_address_device, dma_size,
                             exp_host[i], exp_dev[i], exp_size[i]);
                end
            end
            dl = (done_len == 0) ? $urandom_range(1, 2) : done_len;
            accept_chunk(tag, i, dl, noise || (rand_hold && $urandom_range(0, 3) == 0), nw);
        end
        busy_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (dma_pending !== 1'b0) busy_seen = 1'b1;
        end
        n_checks++;
        if (busy_seen) begin
            n_fail++;
            $display("[TB] FAIL %s idle_after: dma_pending rose after last chunk, required 0", tag);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (dma_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset pending: got %b required 0", dma_pending);
        end
        n_checks++;
        if (dma_address_host !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset host: got %h required 0", dma_address_host);
        end
        n_checks++;
        if (dma_address_device !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset device: got %h required 0", dma_address_device);
        end
        n_checks++;
        if (dma_size !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset size: got %0d required 0", dma_size);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_read_basic();
        clear_exp();
        push_exp(32'h1000, 32'h000, 128);
        push_exp(32'h1080, 32'h080, 128);
        push_exp(32'h1100, 32'h100, 44);
        run_transfer("read_basic", 32'h1000, 32'h0, 32'd300, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
        // Low address/size bits are ignored
        run_transfer("read_lowbits", 32'h1003, 32'h3, 32'd303, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_write_payload();
        clear_exp();
        push_exp(32'h000, 32'h2000, 256);
        push_exp(32'h100, 32'h2100, 256);
        run_transfer("write_256", 32'h0, 32'h2000, 32'd512, 1'b1, 16'h0020, 1, 1'b0, 1'b0);
        clear_exp();
        push_exp(32'h000, 32'h0, 512);
        push_exp(32'h200, 32'h200, 512);
        run_transfer("write_clamp", 32'h0, 32'h0, 32'd1024, 1'b1, 16'h00E0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_4k_cross();
        clear_exp();
        push_exp(32'h0FC0, 32'h000, 64);
        push_exp(32'h1000, 32'h040, 512);
        push_exp(32'h1200, 32'h240, 448);
        run_transfer("cross_4k", 32'h0FC0, 32'h0, 32'd1024, 1'b0, 16'h5000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_align();
        clear_exp();
`ifdef TRANSMISSION_SPLITTER_ALIGN_EN
        push_exp(32'h1040, 32'h000, 64);
        push_exp(32'h1080, 32'h040, 128);
        push_exp(32'h1100, 32'h0C0, 64);
`else
        push_exp(32'h1040, 32'h000, 128);
        push_exp(32'h10C0, 32'h080, 128);
`endif
        run_transfer("align", 32'h1040, 32'h0, 32'd256, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_device_wrap();
        clear_exp();
        push_exp(32'h2000, 32'hFFFF_FF80, 128);
        push_exp(32'h2080, 32'h0000_0000, 128);
        run_transfer("dev_wrap", 32'h2000, 32'hFFFF_FF80, 32'd256, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
    endtask

    // conf_valid while pending is ignored; dma_done held through the bubble acts once
    task automatic test_handshake();
        clear_exp();
        push_exp(32'h1000, 32'h000, 128);
        push_exp(32'h1080, 32'h080, 128);
        push_exp(32'h1100, 32'h100, 44);
        run_transfer("conf_ignored", 32'h1000, 32'h0, 32'd300, 1'b0, 16'h0000, 1, 1'b1, 1'b0);
        run_transfer("done_held", 32'h1000, 32'h0, 32'd300, 1'b0, 16'h0000, 2, 1'b0, 1'b0);
    endtask

    // Zero-length transfers and stray dma_done pulses in IDLE do nothing
    task automatic test_zero_and_stray();
        bit busy_seen;
        start_transfer("zero_size", 32'h4000, 32'h0, 32'd3, 1'b0, 16'h0000);
        @(negedge i_clk);
        dma_done = 1'b1;
        @(negedge i_clk);
        dma_done = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (dma_pending !== 1'b0) busy_seen = 1'b1;
        end
        n_checks++;
        if (busy_seen) begin
            n_fail++;
            $display("[TB] FAIL zero_size idle: dma_pending rose, required 0");
        end
    endtask

    task automatic test_reset_mid();
        int nw;
        clear_exp();
        push_exp(32'h1000, 32'h000, 128);
        push_exp(32'h1080, 32'h080, 128);
        push_exp(32'h1100, 32'h100, 44);
        start_transfer("reset_mid", 32'h1000, 32'h0, 32'd300, 1'b0, 16'h0000);
        wait_chunk("reset_mid", 0, 1);
        accept_chunk("reset_mid", 0, 1, 1'b0, nw);
        wait_chunk("reset_mid", 1, nw);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if (dma_pending !== 1'b0 || dma_address_host !== 32'd0 ||
            dma_address_device !== 32'd0 || dma_size !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid outputs: pend=%b host=%h dev=%h size=%0d required all 0",
                     dma_pending, dma_address_host, dma_address_device, dma_size);
        end
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (dma_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid no_resume: dma_pending=%b required 0", dma_pending);
        end
        run_transfer("after_reset", 32'h1000, 32'h0, 32'd300, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] h;
        logic [31:0] d;
        logic [31:0] s;
        logic        dir;
        logic [15:0] dc;
        for (int t = 0; t < 40; t++) begin
            h   = $urandom;
            if (t % 4 == 0) h = 32'hFFFF_F000 | (h & 32'hFFF);
            d   = $urandom;
            s   = $urandom_range(1, 4096);
            dir = 1'($urandom_range(0, 1));
            dc  = 16'($urandom);
            model_build(h, d, s, dir, dc);
            run_transfer("random", h, d, s, dir, dc, 0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        i_rst                     = 1'b1;
        pcie_dcommand             = 16'h0;
        conf_start_address_host   = 32'h0;
        conf_start_address_device = 32'h0;
        conf_size                 = 32'h0;
        conf_dir_write            = 1'b0;
        conf_valid                = 1'b0;
        dma_done                  = 1'b0;
        $display("[TB] transmission_splitter bench start");
        test_reset();
        test_read_basic();
        test_write_payload();
        test_4k_cross();
        test_align();
        test_device_wrap();
        test_handshake();
        test_zero_and_stray();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
